fetch_exec_unit: RTL and testbench
==================================

FETCH_EXEC_UNIT -- requirements
Module: fetch_exec_unit

Interface
REQ-001 The block SHALL have port clk, input, 1, rising-edge system clock.
REQ-002 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 The block SHALL have port cs, input, 3, controller state code: 000 IDLE, 001 FETCHA, 010 FETCHB, 011 EXECA, 100 EXECB.
REQ-004 The block SHALL have port mem_rdata, input, 8, program memory read data, combinational from mem_addr.
REQ-005 The block SHALL have port mem_addr, output, 8, program memory address; it SHALL equal pc.
REQ-006 The block SHALL have port pc, output, 8, program counter.
REQ-007 The block SHALL have port acc, output, 8, accumulator.
REQ-008 The block SHALL have port zf / cf, output, 1 each, zero and carry flags.
REQ-009 The block SHALL have port out_data, output, 8, output port register; out_valid, output, 1, one-cycle write strobe.
REQ-010 The block SHALL have ports cont and halt, output, 1 each, controller feedback, combinational.
REQ-011 The block SHALL have port err, output, 1, sticky error flag.

Function
REQ-012 In FETCHA, on the clock edge, the block SHALL load opcode <= mem_rdata and set pc <= pc+1.
REQ-013 In FETCHB, on the clock edge, the block SHALL load operand <= mem_rdata and set pc <= pc+1.
REQ-014 pc SHALL wrap modulo 256 (FF+1 = 00); the wrap SHALL NOT set err.
REQ-015 In EXECA the block SHALL execute opcode[7:4] with op = operand: 0 NOP; 1 LDI acc<=op; 2 ADD {cf,acc}<=acc+op; 3 SUB {cf,acc}<=acc-op (cf = borrow); 4 AND; 5 XOR; 6 JMP pc<=op; 7 OUT (two-cycle); F HALT.
REQ-016 zf SHALL update to (new acc==0) only on opcodes 1-5; cf SHALL update only on opcodes 2-3 and hold otherwise.
REQ-017 halt SHALL be 1 exactly when cs==EXECA and opcode[7:4]==F, else 0.
REQ-018 cont SHALL be 1 exactly when cs==EXECA and opcode[7:4]==7, else 0.
REQ-019 OUT: in EXECA the block SHALL set acc<=acc+op (cf and zf unchanged); in the following EXECB it SHALL set out_data<=acc and pulse out_valid high for one cycle.
REQ-020 In EXECB with a latched opcode other than 7, the block SHALL make no register change and SHALL set err.
REQ-021 In EXECA, opcodes 8-E SHALL behave as NOP and SHALL set err.
REQ-022 Illegal cs codes 101-111 SHALL cause no update of pc, opcode, operand, acc, flags or out_data, and SHALL set err.
REQ-023 In IDLE all registers SHALL hold, so that a later run resumes fetching at the current pc.
REQ-024 HALT SHALL leave pc pointing past the HALT operand; re-run resumes there.
REQ-025 out_valid SHALL be registered and SHALL be low in every cycle other than the one following the EXECB edge of an OUT.
REQ-026 err SHALL stay set once set, until reset.

Reset
REQ-027 When reset is low, pc, opcode, operand, acc, out_data SHALL be 00; zf SHALL be 1; cf, out_valid and err SHALL be 0; all take effect immediately, without a clock.
REQ-028 cont and halt SHALL be 0 during reset because they are combinational from cs.
REQ-029 Reset asserted mid-instruction SHALL discard the partial opcode/operand; after release, execution SHALL restart at pc=00.

Verification
REQ-030 Program 10 05 20 FB, cs driven FETCHA,FETCHB,EXECA twice -> acc=00, cf=1, zf=1, pc=04.
REQ-031 Program 10 03 70 04, cs sequence ...EXECA,EXECB -> cont=1 during EXECA only; out_data=07 and out_valid high exactly one cycle; pc=04.
REQ-032 Program F0 00 -> halt=1 during EXECA, 0 otherwise; pc=02; IDLE for 5 cycles leaves all registers unchanged.
REQ-033 Program 60 FE at pc=00, then opcode fetch at FE/FF -> JMP sets pc=FE; the fetch at FF wraps pc to 00; err stays 0.
REQ-034 cs=110 for one cycle after LDI 5A -> acc stays 5A and err=1; err persists through further legal instructions.
REQ-035 reset pulsed low during FETCHB of 20 11 -> all outputs at reset values immediately; after release pc=00, acc=00.

Source files
------------

// File: rtl/fetch_exec_unit.sv
// Fetch/execute datapath for a tiny 8-bit accumulator machine. The external
// controller sequences it through cs; this block owns pc, acc, flags and the output port.
module fetch_exec_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] cs,
  input  logic [7:0] mem_rdata,
  output logic [7:0] mem_addr,
  output logic [7:0] pc,
  output logic [7:0] acc,
  output logic       zf,
  output logic       cf,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       cont,
  output logic       halt,
  output logic       err
);

  localparam logic [2:0] CS_IDLE   = 3'b000;
  localparam logic [2:0] CS_FETCHA = 3'b001;
  localparam logic [2:0] CS_FETCHB = 3'b010;
  localparam logic [2:0] CS_EXECA  = 3'b011;
  localparam logic [2:0] CS_EXECB  = 3'b100;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_OUT  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Nine-bit add/subtract; bit 8 is the carry (add) or borrow (subtract).
  function automatic logic [8:0] add9(input logic [7:0] a, input logic [7:0] b);
    add9 = {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [8:0] sub9(input logic [7:0] a, input logic [7:0] b);
    sub9 = {1'b0, a} - {1'b0, b};
  endfunction

  logic [7:0] pc_q, pc_d;
  // Only the instruction-class nibble of the opcode byte affects behaviour.
  logic [3:0] opcode_q, opcode_d;
  logic [7:0] operand_q, operand_d;
  logic [7:0] acc_q, acc_d;
  logic       zf_q, zf_d;
  logic       cf_q, cf_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       err_q, err_d;
  logic [8:0] alu_s;

  // Next-state logic for every architectural register, keyed on controller state.
  always_comb begin
    pc_d        = pc_q;
    opcode_d    = opcode_q;
    operand_d   = operand_q;
    acc_d       = acc_q;
    zf_d        = zf_q;
    cf_d        = cf_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    err_d       = err_q;
    alu_s       = 9'd0;
    case (cs)
      CS_IDLE: begin
        pc_d = pc_q;
      end
      CS_FETCHA: begin
        opcode_d = mem_rdata[7:4];
        pc_d     = pc_q + 8'd1;
      end
      CS_FETCHB: begin
        operand_d = mem_rdata;
        pc_d      = pc_q + 8'd1;
      end
      CS_EXECA: begin
        case (opcode_q)
          OP_NOP, OP_HALT: begin
            acc_d = acc_q;
          end
          OP_LDI: begin
            acc_d = operand_q;
            zf_d  = (operand_q == 8'h00);
          end
          OP_ADD: begin
            alu_s = add9(acc_q, operand_q);
            acc_d = alu_s[7:0];
            cf_d  = alu_s[8];
            zf_d  = (alu_s[7:0] == 8'h00);
          end
          OP_SUB: begin
            alu_s = sub9(acc_q, operand_q);
            acc_d = alu_s[7:0];
            cf_d  = alu_s[8];
            zf_d  = (alu_s[7:0] == 8'h00);
          end
          OP_AND: begin
            acc_d = acc_q & operand_q;
            zf_d  = ((acc_q & operand_q) == 8'h00);
          end
          OP_XOR: begin
            acc_d = acc_q ^ operand_q;
            zf_d  = ((acc_q ^ operand_q) == 8'h00);
          end
          OP_JMP: begin
            pc_d = operand_q;
          end
          OP_OUT: begin
            // First half of OUT pre-adds the operand; flags deliberately untouched.
            alu_s = add9(acc_q, operand_q);
            acc_d = alu_s[7:0];
          end
          default: begin
            err_d = 1'b1;
          end
        endcase
      end
      CS_EXECB: begin
        if (opcode_q == OP_OUT) begin
          out_data_d  = acc_q;
          out_valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: begin
        err_d = 1'b1;
      end
    endcase
  end

  // Architectural state registers with immediate reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= 8'h00;
      opcode_q    <= 4'h0;
      operand_q   <= 8'h00;
      acc_q       <= 8'h00;
      zf_q        <= 1'b1;
      cf_q        <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      opcode_q    <= opcode_d;
      operand_q   <= operand_d;
      acc_q       <= acc_d;
      zf_q        <= zf_d;
      cf_q        <= cf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign mem_addr  = pc_q;
  assign pc        = pc_q;
  assign acc       = acc_q;
  assign zf        = zf_q;
  assign cf        = cf_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

  // Controller feedback is combinational so the controller can branch in the same cycle.
  assign cont = (cs == CS_EXECA) && (opcode_q == OP_OUT);
  assign halt = (cs == CS_EXECA) && (opcode_q == OP_HALT);

endmodule

// File: tb/tb_fetch_exec_unit.sv
// Scoreboard bench for fetch_exec_unit: an instruction-level model queues expected
// state snapshots and OUT bytes; a negedge monitor pops and compares them.
module tb_fetch_exec_unit;

  logic       clk;
  logic       reset;
  logic [2:0] cs;
  logic [7:0] mem_rdata, mem_addr, pc, acc, out_data;
  logic       zf, cf, out_valid, cont, halt, err;

  logic [7:0] mem [0:255];
  assign mem_rdata = mem[mem_addr];

  fetch_exec_unit dut (
    .clk(clk), .reset(reset), .cs(cs), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .pc(pc), .acc(acc), .zf(zf), .cf(cf), .out_data(out_data), .out_valid(out_valid),
    .cont(cont), .halt(halt), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [2:0] IDLE = 3'b000, FA = 3'b001, FB = 3'b010, EA = 3'b011, EB = 3'b100;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] addr;
    logic [7:0] acc;
    logic [7:0] out;
    logic       zf;
    logic       cf;
    logic       err;
  } snap_t;

  int total = 0;
  int bad = 0;

  // Reference machine state, instruction-level.
  int m_pc, m_acc, m_out, m_opc, m_opr;
  bit m_zf, m_cf, m_err;

  snap_t      sq[$];
  logic [7:0] oq[$];
  logic       chk_req = 1'b0;
  logic       exp_cont = 1'b0;
  logic       exp_halt = 1'b0;

  function automatic snap_t model_snap();
    snap_t s;
    s.pc   = 8'(m_pc);
    s.addr = 8'(m_pc);
    s.acc  = 8'(m_acc);
    s.out  = 8'(m_out);
    s.zf   = m_zf;
    s.cf   = m_cf;
    s.err  = m_err;
    return s;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_acc = 0; m_out = 0; m_opc = 0; m_opr = 0;
    m_zf = 1'b1; m_cf = 1'b0; m_err = 1'b0;
  endtask

  task automatic exec_a();
    int s;
    case (m_opc / 16)
      1: begin m_acc = m_opr; m_zf = (m_acc == 0); end
      2: begin s = m_acc + m_opr; m_cf = (s > 255); m_acc = s % 256; m_zf = (m_acc == 0); end
      3: begin m_cf = (m_acc < m_opr); m_acc = (m_acc - m_opr + 256) % 256; m_zf = (m_acc == 0); end
      4: begin m_acc = m_acc & m_opr; m_zf = (m_acc == 0); end
      5: begin m_acc = m_acc ^ m_opr; m_zf = (m_acc == 0); end
      6: m_pc = m_opr;
      7: m_acc = (m_acc + m_opr) % 256;
      8, 9, 10, 11, 12, 13, 14: m_err = 1'b1;
      default: ;
    endcase
  endtask

  task automatic exec_b();
    if (m_opc / 16 == 7) begin
      m_out = m_acc;
      oq.push_back(8'(m_acc));
    end else begin
      m_err = 1'b1;
    end
  endtask

  // One controller cycle; cont/halt expectations follow the latched opcode class.
  task automatic cyc(input logic [2:0] c);
    cs = c;
    exp_cont = (c == EA) && (m_opc / 16 == 7);
    exp_halt = (c == EA) && (m_opc / 16 == 15);
    @(posedge clk);
    #1;
  endtask

  task automatic check_state();
    cs = IDLE; exp_cont = 1'b0; exp_halt = 1'b0;
    sq.push_back(model_snap());
    chk_req = 1'b1;
    @(posedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic run_instr(input bit stray_b, input int idles, input bit bad_cs);
    cyc(FA);
    m_opc = int'(mem[m_pc]); m_pc = (m_pc + 1) % 256;
    for (int i = 0; i < idles; i++) cyc(IDLE);
    if (bad_cs) begin
      cyc(3'(5 + $urandom % 3));
      m_err = 1'b1;
    end
    cyc(FB);
    m_opr = int'(mem[m_pc]); m_pc = (m_pc + 1) % 256;
    cyc(EA);
    exec_a();
    if (m_opc / 16 == 7 || stray_b) begin
      cyc(EB);
      exec_b();
    end
    check_state();
  endtask

  // Reset asserted between clock edges, checked before any further edge.
  task automatic do_reset();
    cs = IDLE; exp_cont = 1'b0; exp_halt = 1'b0;
    reset = 1'b0;
    model_reset();
    #2;
    sq.push_back(model_snap());
    chk_req = 1'b1;
    @(posedge clk);
    #1;
    chk_req = 1'b0;
    reset = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    logic [3:0] nib;
    r = $urandom % 10;
    if (r < 8) nib = 4'(r);
    else if (r == 8) nib = 4'hF;
    else nib = 4'(8 + $urandom % 7);
    return {nib, 4'($urandom % 16)};
  endfunction

  // Monitor: compares feedback every cycle, and pops queues when the DUT presents data.
  always @(negedge clk) begin
    snap_t got, exp_s;
    logic [7:0] exp_o;
    total++;
    if (cont !== exp_cont || halt !== exp_halt) begin
      bad++;
      $display("FAIL cont_halt t=%0t got=%b%b exp=%b%b", $time, cont, halt, exp_cont, exp_halt);
    end
    if (out_valid !== 1'b0) begin
      total++;
      if (oq.size() == 0) begin
        bad++;
        $display("FAIL out_valid t=%0t got=%b exp=0", $time, out_valid);
      end else begin
        exp_o = oq.pop_front();
        if (out_data !== exp_o) begin
          bad++;
          $display("FAIL out_data t=%0t got=%h exp=%h", $time, out_data, exp_o);
        end
      end
    end
    if (chk_req) begin
      total++;
      got = '{pc, mem_addr, acc, out_data, zf, cf, err};
      if (sq.size() == 0) begin
        bad++;
        $display("FAIL state t=%0t no expected snapshot", $time);
      end else begin
        exp_s = sq.pop_front();
        if (got !== exp_s) begin
          bad++;
          $display("FAIL state t=%0t got pc=%h addr=%h acc=%h out=%h zf=%b cf=%b err=%b exp pc=%h addr=%h acc=%h out=%h zf=%b cf=%b err=%b",
                   $time, got.pc, got.addr, got.acc, got.out, got.zf, got.cf, got.err,
                   exp_s.pc, exp_s.addr, exp_s.acc, exp_s.out, exp_s.zf, exp_s.cf, exp_s.err);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    cs = IDLE;
    clear_mem();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // LDI 05; ADD FB -> wrap to 00 with carry
    mem[0] = 8'h10; mem[1] = 8'h05; mem[2] = 8'h20; mem[3] = 8'hFB;
    run_instr(1'b0, 0, 1'b0);
    run_instr(1'b0, 0, 1'b0);

    // LDI 03; OUT 04 -> port gets 07
    do_reset();
    mem[0] = 8'h10; mem[1] = 8'h03; mem[2] = 8'h70; mem[3] = 8'h04;
    run_instr(1'b0, 0, 1'b0);
    run_instr(1'b0, 0, 1'b0);

    // HALT, then idle cycles must leave everything as it was
    do_reset();
    clear_mem();
    mem[0] = 8'hF0; mem[1] = 8'h00;
    run_instr(1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(IDLE);
    check_state();

    // JMP FE, then fetch across the FF->00 boundary
    do_reset();
    mem[0] = 8'h60; mem[1] = 8'hFE; mem[8'hFE] = 8'h10; mem[8'hFF] = 8'hAB;
    run_instr(1'b0, 0, 1'b0);
    run_instr(1'b0, 0, 1'b0);

    // LDI 5A, illegal cs, then a legal XOR with err staying set
    do_reset();
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h5A; mem[2] = 8'h50; mem[3] = 8'h0F;
    run_instr(1'b0, 0, 1'b0);
    cyc(3'b110);
    m_err = 1'b1;
    check_state();
    run_instr(1'b0, 0, 1'b0);

    // Stray EXECB and reserved opcode both flag err
    do_reset();
    mem[0] = 8'h10; mem[1] = 8'h22; mem[2] = 8'h9C; mem[3] = 8'h44;
    run_instr(1'b1, 0, 1'b0);
    do_reset();
    run_instr(1'b0, 0, 1'b0);
    run_instr(1'b0, 1, 1'b0);

    // Reset mid-instruction: ADD 11 interrupted during FETCHB
    do_reset();
    mem[0] = 8'h20; mem[1] = 8'h11;
    cyc(FA);
    m_opc = int'(mem[m_pc]); m_pc = (m_pc + 1) % 256;
    cs = FB; exp_cont = 1'b0; exp_halt = 1'b0;
    do_reset();
    check_state();

    // Randomized programs
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int i = 0; i < 256; i++) mem[i] = rand_byte();
      for (int n = 0; n < 100; n++) begin
        run_instr(($urandom % 16) == 0, (($urandom % 4) == 0) ? 1 : 0, ($urandom % 50) == 0);
      end
    end

    @(posedge clk);
    #1;
    total++;
    if (sq.size() != 0 || oq.size() != 0) begin
      bad++;
      $display("FAIL drain got snap=%0d out=%0d exp snap=0 out=0", sq.size(), oq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
